// File: rtl/dmem_block_mover_if.sv
// Bundle of the block mover's command/status handshake and its data-memory port.
// The slave side is the mover itself; the master side is the requester plus the memory.
interface dmem_block_mover_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] fill_val;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] sum;
  logic              mem_e;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output start, op, src, dst, len, fill_val, mem_rdata,
    input  busy, done, err, sum, mem_e, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  start, op, src, dst, len, fill_val, mem_rdata,
    output busy, done, err, sum, mem_e, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_block_mover.sv
// Data-memory block mover: copies or fills len bytes one at a time in ascending order,
// accumulating a byte sum of everything written. All outputs come straight from flops.
module dmem_block_mover #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_block_mover_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO_LEN = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic              op_r, op_s;
  logic [ADDR_W-1:0] src_r, src_s;
  logic [ADDR_W-1:0] dst_r, dst_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [ADDR_W:0]   i_r, i_s, i_inc_s;
  logic [DATA_W-1:0] fill_r, fill_s;
  logic [DATA_W-1:0] sum_r, sum_s;
  logic              err_r, err_s;
  logic              busy_r, done_r, mem_e_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

  // Next-state decode; memory outputs are computed for the state being entered so they can be registered.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    src_s       = src_r;
    dst_s       = dst_r;
    len_s       = len_r;
    i_s         = i_r;
    fill_s      = fill_r;
    sum_s       = sum_r;
    err_s       = err_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    i_inc_s     = i_r + ONE_LEN;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          op_s   = bus.op;
          src_s  = bus.src;
          dst_s  = bus.dst;
          len_s  = bus.len;
          fill_s = bus.fill_val;
          sum_s  = {DATA_W{1'b0}};
          i_s    = {(ADDR_W+1){1'b0}};
          if (bus.len == ZERO_LEN) begin
            state_s = FIN;
            err_s   = 1'b0;
          end else if (bus.len > MAX_LEN) begin
            state_s = FIN;
            err_s   = 1'b1;
          end else if (bus.op) begin
            state_s     = WR;
            err_s       = 1'b0;
            mem_addr_s  = bus.dst;
            mem_wdata_s = bus.fill_val;
          end else begin
            state_s    = RD;
            err_s      = 1'b0;
            mem_addr_s = bus.src;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        // The read byte lands directly in the write-data flop, which doubles as the data register.
        state_s     = WR;
        mem_addr_s  = dst_r + i_r[ADDR_W-1:0];
        mem_wdata_s = bus.mem_rdata;
      end
      WR: begin
        sum_s = sum_r + mem_wdata_r;
        i_s   = i_inc_s;
        if (i_inc_s == len_r) begin
          state_s = FIN;
        end else if (op_r) begin
          state_s     = WR;
          mem_addr_s  = dst_r + i_inc_s[ADDR_W-1:0];
          mem_wdata_s = fill_r;
        end else begin
          state_s    = RD;
          mem_addr_s = src_r + i_inc_s[ADDR_W-1:0];
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 1'b0;
      src_r       <= {ADDR_W{1'b0}};
      dst_r       <= {ADDR_W{1'b0}};
      len_r       <= {(ADDR_W+1){1'b0}};
      i_r         <= {(ADDR_W+1){1'b0}};
      fill_r      <= {DATA_W{1'b0}};
      sum_r       <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_e_r     <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      src_r       <= src_s;
      dst_r       <= dst_s;
      len_r       <= len_s;
      i_r         <= i_s;
      fill_r      <= fill_s;
      sum_r       <= sum_s;
      err_r       <= err_s;
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == FIN);
      mem_e_r     <= (state_s == RD) || (state_s == WR);
      mem_we_r    <= (state_s == WR);
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.sum       = sum_r;
  assign bus.mem_e     = mem_e_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: directed operations push expected results to a scoreboard,
// and a monitor checks them against the DUT each time done pulses.
module tb_dmem_block_mover;

  typedef struct {
    logic        err;
    int          sum;
    int          lat;
    int          wr;
    int          acc;
    int          base;
    int          n;
    logic [31:0] vals;
    int          wr0;
    int          acc0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       pl_en;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  logic [7:0] mem [16];
  int         cyc;
  int         wr_cnt;
  int         acc_cnt;
  int         done_cnt;
  int         t_start;
  int         n_chk;
  int         n_fail;
  exp_t       sb[$];
  exp_t       mon_e;

  dmem_block_mover_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  dmem_block_mover #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = bus.mem_e ? mem[bus.mem_addr] : 8'h00;

  // Memory model, preload port and access counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_e) acc_cnt <= acc_cnt + 1;
    if (bus.mem_e && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc - t_start + 1, mon_e.lat);
        chk("err", int'(bus.err), int'(mon_e.err));
        chk("sum", int'(bus.sum), mon_e.sum);
        chk("busy_with_done", int'(bus.busy), 1);
        chk("writes", wr_cnt - mon_e.wr0, mon_e.wr);
        chk("accesses", acc_cnt - mon_e.acc0, mon_e.acc);
        for (int k = 0; k < mon_e.n; k++) begin
          chk("mem_byte", int'(mem[4'(mon_e.base + k)]), int'(mon_e.vals[8*k +: 8]));
        end
      end
    end
  end

  task automatic expect_op(input logic e, input int s, input int lat, input int wr, input int acc,
                           input int base, input int n, input logic [31:0] vals);
    exp_t x;
    x.err = e; x.sum = s; x.lat = lat; x.wr = wr; x.acc = acc;
    x.base = base; x.n = n; x.vals = vals; x.wr0 = wr_cnt; x.acc0 = acc_cnt;
    sb.push_back(x);
  endtask

  task automatic poke_mem(input int a, input int d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a[3:0]; pl_data = d[7:0];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one operation; poke >= 0 pulses a conflicting start that many cycles into the operation.
  task automatic run_op(input bit o, input int s, input int d, input int l, input int fv,
                        input int poke, input bit rel);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    bus.start = 1'b1; bus.op = o; bus.src = s[3:0]; bus.dst = d[3:0];
    bus.len = l[4:0]; bus.fill_val = fv[7:0];
    @(posedge clk);
    #1 t_start = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 100 && done_cnt == d0; k++) begin
      if (k == poke) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.dst = 4'd0; bus.len = 5'd2; bus.fill_val = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", int'(done_cnt != d0), 1);
    @(negedge clk);
    chk("busy_after", int'(bus.busy), 0);
    chk("done_after", int'(bus.done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr_before;
    int d0;
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = 4'd0; pl_data = 8'd0;
    bus.start = 1'b0; bus.op = 1'b0; bus.src = 4'd0; bus.dst = 4'd0;
    bus.len = 5'd0; bus.fill_val = 8'd0;
    cyc = 0; wr_cnt = 0; acc_cnt = 0; done_cnt = 0; t_start = 0; n_chk = 0; n_fail = 0;

    for (int a = 0; a < 16; a++) poke_mem(a, 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_mem_e", int'(bus.mem_e), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst_sum", int'(bus.sum), 0);

    // Fill accepted on the first edge after reset release.
    expect_op(1'b0, 'hEF, 4, 3, 3, 4, 3, 32'h00A5A5A5);
    run_op(1'b1, 0, 4, 3, 'hA5, -1, 1'b1);

    // Copy with a start pulse while busy that must be ignored.
    poke_mem(0, 'h01); poke_mem(1, 'h02); poke_mem(2, 'h03); poke_mem(3, 'h04);
    expect_op(1'b0, 'h0A, 9, 4, 8, 8, 4, 32'h04030201);
    run_op(1'b0, 0, 8, 4, 0, 2, 1'b0);
    chk("ignored_start_mem0", int'(mem[0]), 'h01);

    // Wrapping copy: third read sees the byte just written to address 0.
    poke_mem(14, 'h21); poke_mem(15, 'h32);
    expect_op(1'b0, 'h74, 7, 3, 6, 0, 3, 32'h00213221);
    run_op(1'b0, 14, 0, 3, 0, -1, 1'b0);

    // Overlapping copy propagates mem[0] forward.
    poke_mem(0, 'h11);
    expect_op(1'b0, 'h33, 7, 3, 6, 1, 3, 32'h00111111);
    run_op(1'b0, 0, 1, 3, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("sum_hold", int'(bus.sum), 'h33);

    // Zero length, then over-length, then a valid start clearing err.
    expect_op(1'b0, 'h00, 1, 0, 0, 0, 0, 32'h0);
    run_op(1'b0, 3, 5, 0, 0, -1, 1'b0);
    expect_op(1'b1, 'h00, 1, 0, 0, 0, 0, 32'h0);
    run_op(1'b1, 0, 0, 17, 'h77, -1, 1'b0);
    repeat (2) @(negedge clk);
    chk("err_hold", int'(bus.err), 1);
    expect_op(1'b0, 'h3C, 2, 1, 1, 7, 1, 32'h0000003C);
    run_op(1'b1, 0, 7, 1, 'h3C, -1, 1'b0);

    // Reset during the second write of a 4-byte fill.
    wr_before = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.dst = 4'd12; bus.len = 5'd4; bus.fill_val = 8'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_mem_e", int'(bus.mem_e), 0);
    chk("abort_mem_we", int'(bus.mem_we), 0);
    chk("abort_sum", int'(bus.sum), 0);
    repeat (4) @(negedge clk);
    chk("abort_writes", wr_cnt - wr_before, 1);
    chk("abort_mem12", int'(mem[12]), 'h5A);
    chk("abort_mem13", int'(mem[13]), 'h00);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_sb_empty", sb.size(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
